// File: rtl/opfb_fir_cfg_hls_deadlock_reporter.sv
// Deadlock reporter for the OPFB FIR config HLS core.
//
// Watches the per-monitor block flags. Once any flag has stayed high for THRESH
// consecutive cycles, the block takes a snapshot of the flags and the
// axis_block_info bits. It then sends a two-beat report (header, then payload)
// on an AXI-Stream style port. After the report it holds a sticky deadlock flag
// until clear is pulsed.
//
// Ports:
//   ap_clk, ap_rst_n   clock; asynchronous active-low reset (release synchronised)
//   mon_block          per-monitor block flag
//   mon_info           per-monitor axis_block_info, monitor i at [i*INFO_W +: INFO_W]
//   clear              single-cycle re-arm request
//   rpt_tdata/tvalid/tready/tlast  report stream
//   deadlock           sticky deadlock flag
//   report_cnt         completed reports, saturating at 255
module opfb_fir_cfg_hls_deadlock_reporter #(
    parameter int unsigned NUM_MON = 2,
    parameter int unsigned INFO_W  = 1,
    parameter int unsigned THRESH  = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic [NUM_MON-1:0]        mon_block,
    input  logic [NUM_MON*INFO_W-1:0] mon_info,
    input  logic                      clear,
    output logic [31:0]               rpt_tdata,
    output logic                      rpt_tvalid,
    input  logic                      rpt_tready,
    output logic                      rpt_tlast,
    output logic                      deadlock,
    output logic [7:0]                report_cnt
);

    localparam int unsigned InfoBits = NUM_MON * INFO_W;

    typedef enum logic [2:0] {StIdle, StQualify, StSendHdr, StSendPay, StHold} state_e;

    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_MON-1:0]   snap_block_q, snap_block_d;
    logic [InfoBits-1:0]  snap_info_q, snap_info_d;
    logic [7:0]           report_cnt_q, report_cnt_d;
    logic [1:0]           rst_sync_q;
    logic                 rst_int_n;
    logic                 any_block;
    logic [7:0]           low_idx;

    // Reset asserts immediately but releases two edges later, so no state
    // register can leave reset on the same edge that ap_rst_n rises.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];
    assign any_block = |mon_block;

    // State register
    always_ff @(posedge ap_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            snap_block_q <= '0;
            snap_info_q  <= '0;
            report_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_block_q <= snap_block_d;
            snap_info_q  <= snap_info_d;
            report_cnt_q <= report_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_block_d = snap_block_q;
        snap_info_d  = snap_info_q;
        report_cnt_d = report_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_block) begin
                    if (THRESH == 1) begin
                        snap_block_d = mon_block;
                        snap_info_d  = mon_info;
                        cnt_d        = '0;
                        state_d      = StSendHdr;
                    end else begin
                        cnt_d   = 16'd1;
                        state_d = StQualify;
                    end
                end
            end
            StQualify: begin
                // clear takes priority over a qualifying sample.
                if (clear || !any_block) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == 16'(THRESH - 1)) begin
                    snap_block_d = mon_block;
                    snap_info_d  = mon_info;
                    cnt_d        = '0;
                    state_d      = StSendHdr;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSendHdr: begin
                if (rpt_tready) begin
                    state_d = StSendPay;
                end
            end
            StSendPay: begin
                if (rpt_tready) begin
                    state_d = StHold;
                    if (report_cnt_q != 8'hFF) begin
                        report_cnt_d = report_cnt_q + 8'd1;
                    end
                end
            end
            StHold: begin
                if (clear) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lowest set index of the snapshot (scan high to low so the lowest wins).
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
            if (snap_block_q[i]) begin
                low_idx = 8'(i);
            end
        end
    end

    // Outputs are decoded from registered state only, so the beat stays stable
    // while the consumer stalls.
    always_comb begin
        rpt_tdata  = '0;
        rpt_tvalid = 1'b0;
        rpt_tlast  = 1'b0;
        deadlock   = (state_q == StHold);
        report_cnt = report_cnt_q;
        unique case (state_q)
            StSendHdr: begin
                rpt_tvalid = 1'b1;
                rpt_tdata  = {8'hDE, 8'(NUM_MON), 8'd0, low_idx};
            end
            StSendPay: begin
                rpt_tvalid = 1'b1;
                rpt_tlast  = 1'b1;
                rpt_tdata  = {8'(snap_block_q), 24'(snap_info_q)};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_opfb_fir_cfg_hls_deadlock_reporter.sv
module tb_opfb_fir_cfg_hls_deadlock_reporter;

    localparam int unsigned Thresh = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [1:0]  mon_block = '0;
    logic [1:0]  mon_info = '0;
    logic        clear = 1'b0;
    logic        rpt_tready = 1'b0;
    logic [31:0] rpt_tdata;
    logic        rpt_tvalid;
    logic        rpt_tlast;
    logic        deadlock;
    logic [7:0]  report_cnt;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [32:0] exp_q[$];

    opfb_fir_cfg_hls_deadlock_reporter #(
        .NUM_MON(2),
        .INFO_W (1),
        .THRESH (Thresh)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .mon_block (mon_block),
        .mon_info  (mon_info),
        .clear     (clear),
        .rpt_tdata (rpt_tdata),
        .rpt_tvalid(rpt_tvalid),
        .rpt_tready(rpt_tready),
        .rpt_tlast (rpt_tlast),
        .deadlock  (deadlock),
        .report_cnt(report_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: a beat transfers on the next rising edge when valid&ready at the negedge.
    always @(negedge ap_clk) begin
        if (ap_rst_n && rpt_tvalid && rpt_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", {rpt_tlast, rpt_tdata});
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rpt_tlast, rpt_tdata} !== e) begin
                    failures++;
                    $display("FAIL sb_beat actual=%h required=%h", {rpt_tlast, rpt_tdata}, e);
                end
            end
        end
    end

    function automatic logic [32:0] hdr_beat(input logic [1:0] blk);
        logic [7:0] idx;
        idx = blk[0] ? 8'd0 : 8'd1;
        return {1'b0, 8'hDE, 8'd2, 8'd0, idx};
    endfunction

    function automatic logic [32:0] pay_beat(input logic [1:0] blk, input logic [1:0] info);
        return {1'b1, 6'd0, blk, 22'd0, info};
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push_report(input logic [1:0] blk, input logic [1:0] info);
        exp_q.push_back(hdr_beat(blk));
        exp_q.push_back(pay_beat(blk, info));
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
    endtask

    task automatic leave_hold();
        mon_block = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Block applied now; report must appear exactly Thresh edges later.
    task automatic check_latency(input string name);
        for (int i = 1; i < int'(Thresh); i++) tick();
        checks++;
        if (rpt_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_early actual=%b required=0", name, rpt_tvalid);
        end
        tick();
        checks++;
        if (rpt_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL %s_exact actual=%b required=1", name, rpt_tvalid);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        #13;
        checks++;
        if ({rpt_tvalid, rpt_tlast, rpt_tdata, deadlock, report_cnt} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0",
                     {rpt_tvalid, rpt_tlast, rpt_tdata, deadlock, report_cnt});
        end
        tick();
        ap_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({rpt_tvalid, deadlock, report_cnt} !== 10'd0) begin
            failures++;
            $display("FAIL reset_idle actual=%h required=0", {rpt_tvalid, deadlock, report_cnt});
        end
    endtask

    task automatic test_basic();
        rpt_tready = 1'b1;
        mon_info = 2'b01;
        mon_block = 2'b10;
        push_report(2'b10, 2'b01);
        check_latency("basic_latency");
        tick();
        tick();
        checks++;
        if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt) || rpt_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL basic_done actual=%b/%0d required=1/%0d", deadlock, report_cnt, exp_cnt);
        end
    endtask

    task automatic test_no_qualify();
        logic seen;
        leave_hold();
        checks++;
        if (deadlock !== 1'b0) begin
            failures++;
            $display("FAIL nq_clear actual=%b required=0", deadlock);
        end
        mon_block = 2'b01;
        for (int i = 0; i < int'(Thresh) - 1; i++) tick();
        mon_block = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rpt_tvalid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || deadlock !== 1'b0) begin
            failures++;
            $display("FAIL nq_no_report actual=%b/%b required=0/0", seen, deadlock);
        end
        // Counter must have restarted from zero.
        mon_info = 2'b10;
        mon_block = 2'b01;
        push_report(2'b01, 2'b10);
        check_latency("nq_relatency");
        tick();
        tick();
        checks++;
        if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL nq_done actual=%b/%0d required=1/%0d", deadlock, report_cnt, exp_cnt);
        end
    endtask

    task automatic test_clear_rearm();
        mon_block = 2'b11;
        mon_info = 2'b11;
        tick();
        push_report(2'b11, 2'b11);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (deadlock !== 1'b0 || rpt_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL rearm_clear actual=%b/%b required=0/0", deadlock, rpt_tvalid);
        end
        check_latency("rearm_latency");
        tick();
        tick();
        checks++;
        if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL rearm_done actual=%b/%0d required=1/%0d", deadlock, report_cnt, exp_cnt);
        end
    endtask

    task automatic test_clear_in_qualify();
        leave_hold();
        mon_info = 2'b00;
        mon_block = 2'b10;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        push_report(2'b10, 2'b00);
        check_latency("cq_latency");
        tick();
        tick();
        checks++;
        if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL cq_done actual=%b/%0d required=1/%0d", deadlock, report_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        leave_hold();
        rpt_tready = 1'b0;
        mon_info = 2'b01;
        mon_block = 2'b01;
        push_report(2'b01, 2'b01);
        check_latency("bp_latency");
        for (int i = 0; i < 10; i++) begin
            clear = (i == 4);
            tick();
            checks++;
            if (rpt_tvalid !== 1'b1 || rpt_tlast !== 1'b0 || rpt_tdata !== 32'hDE02_0000) begin
                failures++;
                $display("FAIL bp_stall actual=%b/%b/%h required=1/0/de020000",
                         rpt_tvalid, rpt_tlast, rpt_tdata);
            end
        end
        clear = 1'b0;
        rpt_tready = 1'b1;
        for (int k = 0; k < 10 && deadlock !== 1'b1; k++) tick();
        checks++;
        if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_done actual=%b/%0d/%0d required=1/%0d/0",
                     deadlock, report_cnt, exp_q.size(), exp_cnt);
        end
    endtask

    task automatic test_reset_mid_report();
        leave_hold();
        rpt_tready = 1'b0;
        mon_info = 2'b00;
        mon_block = 2'b10;
        exp_q.push_back(hdr_beat(2'b10));
        for (int i = 0; i < int'(Thresh); i++) tick();
        rpt_tready = 1'b1;
        tick();
        rpt_tready = 1'b0;
        checks++;
        if (rpt_tvalid !== 1'b1 || rpt_tlast !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_pay actual=%b/%b required=1/1", rpt_tvalid, rpt_tlast);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if ({rpt_tvalid, rpt_tlast, rpt_tdata, deadlock, report_cnt} !== 43'd0) begin
            failures++;
            $display("FAIL mid_async_reset actual=%h required=0",
                     {rpt_tvalid, rpt_tlast, rpt_tdata, deadlock, report_cnt});
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_sb_left actual=%0d required=0", exp_q.size());
        end
        exp_q.delete();
        mon_info = 2'b01;
        rpt_tready = 1'b1;
        tick();
        tick();
        ap_rst_n = 1'b1;
        push_report(2'b10, 2'b01);
        // Two edges of release synchronisation precede the Thresh qualify edges.
        for (int i = 0; i < int'(Thresh) + 1; i++) tick();
        checks++;
        if (rpt_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_release_early actual=%b required=0", rpt_tvalid);
        end
        tick();
        checks++;
        if (rpt_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL mid_release_exact actual=%b required=1", rpt_tvalid);
        end
        tick();
        tick();
        checks++;
        if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt)) begin
            failures++;
            $display("FAIL mid_fresh_done actual=%b/%0d required=1/%0d", deadlock, report_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] blk;
        logic [1:0] info;
        ap_rst_n = 1'b0;
        mon_block = '0;
        tick();
        ap_rst_n = 1'b1;
        tick();
        tick();
        tick();
        exp_cnt = 0;
        rpt_tready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            blk = 2'($urandom_range(1, 3));
            info = 2'($urandom_range(0, 3));
            mon_info = info;
            mon_block = blk;
            push_report(blk, info);
            for (int k = 0; k < 12 && deadlock !== 1'b1; k++) tick();
            checks++;
            if (deadlock !== 1'b1 || report_cnt !== 8'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_iter%0d actual=%b/%0d required=1/%0d",
                         n, deadlock, report_cnt, exp_cnt);
            end
            leave_hold();
        end
        checks++;
        if (report_cnt !== 8'd255 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sat_final actual=%0d/%0d required=255/0", report_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_qualify();
        test_clear_rearm();
        test_clear_in_qualify();
        test_backpressure();
        test_reset_mid_report();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opfb_fir_cfg_hls_deadlock_reporter.md
OPFB_FIR_CFG_HLS_DEADLOCK_REPORTER -- requirements
Module: opfb_fir_cfg_hls_deadlock_reporter

Interface
REQ-001 SHALL have parameter NUM_MON, default 2, meaning number of deadlock monitors observed (legal range 1..8).
REQ-002 SHALL have parameter INFO_W, default 1, meaning axis_block_info width per monitor (NUM_MON*INFO_W <= 24).
REQ-003 SHALL have parameter THRESH, default 1024, meaning consecutive blocked cycles that qualify a deadlock (legal range 1..65535).
REQ-004 SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port mon_block, input, NUM_MON bits: per-monitor block flag.
REQ-007 SHALL have port mon_info, input, NUM_MON*INFO_W bits: per-monitor axis_block_info, monitor i at bits [i*INFO_W +: INFO_W].
REQ-008 SHALL have port clear, input, 1 bit: single-cycle request to re-arm after a report.
REQ-009 SHALL have port rpt_tdata, output, 32 bits: report stream data.
REQ-010 SHALL have port rpt_tvalid, output, 1 bit: report stream valid.
REQ-011 SHALL have port rpt_tready, input, 1 bit: report stream ready.
REQ-012 SHALL have port rpt_tlast, output, 1 bit: high on the final beat of a report.
REQ-013 SHALL have port deadlock, output, 1 bit: sticky deadlock flag.
REQ-014 SHALL have port report_cnt, output, 8 bits: number of completed reports, saturating at 255.

Function
REQ-015 SHALL implement FSM states IDLE, QUALIFY, SEND_HDR, SEND_PAY, HOLD.
REQ-016 IDLE: if |mon_block, go to QUALIFY with persistence counter = 1; otherwise stay.
REQ-017 QUALIFY: if |mon_block, increment counter (16 bit); if mon_block == 0, return to IDLE and zero the counter.
REQ-018 QUALIFY: the cycle that |mon_block is sampled with counter == THRESH-1 (or immediately on IDLE exit when THRESH == 1), SHALL latch snap_block = mon_block and snap_info = mon_info, then go to SEND_HDR.
REQ-019 SEND_HDR: rpt_tvalid = 1, rpt_tlast = 0, rpt_tdata = {8'hDE, 8'(NUM_MON), 8'd0, 8'(lowest set index in snap_block)}; advance to SEND_PAY on rpt_tvalid & rpt_tready.
REQ-020 SEND_PAY: rpt_tvalid = 1, rpt_tlast = 1, rpt_tdata = {8'(snap_block) zero-extended, 24'(snap_info) zero-extended}; advance to HOLD on handshake.
REQ-021 rpt_tdata and rpt_tlast SHALL be stable while rpt_tvalid = 1 and rpt_tready = 0; rpt_tvalid SHALL NOT drop before the handshake.
REQ-022 Outside SEND_HDR/SEND_PAY, rpt_tvalid = 0, rpt_tlast = 0, and rpt_tdata = 0.
REQ-023 On SEND_PAY handshake, deadlock SHALL go high the next cycle and report_cnt SHALL increment (saturating at 255).
REQ-024 HOLD: deadlock stays 1; mon_block is ignored; clear = 1 SHALL return to IDLE with deadlock = 0 the next cycle.
REQ-025 clear in QUALIFY SHALL return to IDLE and zero the counter; clear in IDLE has no effect.
REQ-026 clear in SEND_HDR/SEND_PAY SHALL be ignored so the in-flight report completes.
REQ-027 Snapshot registers SHALL change only in the REQ-018 latch cycle.
REQ-028 Input-to-rpt_tvalid latency from a block that persists from cycle 0 SHALL be THRESH cycles.

Reset
REQ-029 ap_rst_n = 0 SHALL asynchronously force: state IDLE, counter 0, snapshots 0, rpt_tvalid 0, rpt_tlast 0, rpt_tdata 0, deadlock 0, report_cnt 0.
REQ-030 Reset asserted mid-report SHALL abort the report; after release, the block behaves as if freshly reset.
REQ-031 Reset deassertion SHALL be synchronised to ap_clk; the first state change is no earlier than the second rising edge after release.

Verification
REQ-032 THRESH=4, mon_block=2'b10 held, mon_info=2'b01, rpt_tready=1 -> header 0xDE020001, then payload 0x02000001 with tlast; deadlock=1; report_cnt=1.
REQ-033 THRESH=4, mon_block high 3 cycles then 0 -> no rpt_tvalid, state returns to IDLE, deadlock=0.
REQ-034 Qualified block with rpt_tready=0 for 10 cycles -> header held stable with tvalid=1 throughout; completes after ready rises.
REQ-035 In HOLD, pulse clear with mon_block still high -> deadlock=0, then a new report after THRESH cycles; report_cnt=2.
REQ-036 Assert ap_rst_n=0 during SEND_PAY -> all outputs 0 immediately (without waiting for a clock edge); report_cnt=0.
REQ-037 Drive 256 qualify/clear cycles -> report_cnt saturates at 255.
